tx_frame_seq: RTL and testbench

//  Frame sequencer for the OFDM TX bit source. Per frame request it loads the

---
 rtl/tx_frame_seq.sv | 190 +++++++++++++++++++
 tb/tb_tx_frame_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_seq.sv
// Frame sequencer for the OFDM TX bit source: loads the SIGNAL generator, forwards
// its bits, triggers the payload generator, forwards 8*len payload bits, then clears both.
// The serial output is named do_bit because "do" is a SystemVerilog keyword.
module tx_frame_seq #(
    parameter int SIG_BITS = 24,
    parameter int LEN_W    = 16,
    parameter int MAX_LEN  = 4095,
    parameter int TIMEOUT  = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       rate,
    output logic [LEN_W-1:0] ssg_di_len,
    output logic [3:0]       ssg_di_type,
    output logic             ssg_di_vld,
    input  logic             ssg_do,
    input  logic             ssg_do_vld,
    output logic             pld_rd_en,
    input  logic             pld_do,
    input  logic             pld_do_vld,
    output logic             done_rst,
    output logic             do_bit,
    output logic             do_vld,
    output logic             do_sig,
    output logic             busy,
    output logic             frame_done,
    output logic             err_len,
    output logic             err_timeout
);

    localparam int CNT_W = LEN_W + 3;
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SIG_LD = 3'd1,
        SIG    = 3'd2,
        PLD_LD = 3'd3,
        PLD    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [GAP_W-1:0]   gap, gap_d;
    logic               aborted, aborted_d;
    logic [LEN_W-1:0]   lat_len_d;
    logic [3:0]         lat_type_d;
    logic               do_bit_d, do_vld_d, do_sig_d;
    logic               err_len_d, err_timeout_d;
    logic               len_ok;
    logic [CNT_W-1:0]   pld_last;

    assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
    // Index of the final payload bit: 8*len - 1, using the latched length.
    assign pld_last = {ssg_di_len, 3'b000} - CNT_W'(1);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        gap_d         = gap;
        aborted_d     = aborted;
        lat_len_d     = ssg_di_len;
        lat_type_d    = ssg_di_type;
        do_bit_d      = do_bit;
        do_sig_d      = do_sig;
        do_vld_d      = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        lat_len_d  = len;
                        lat_type_d = rate;
                        aborted_d  = 1'b0;
                        state_d    = SIG_LD;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end

            SIG_LD: begin
                cnt_d   = '0;
                gap_d   = '0;
                state_d = SIG;
            end

            SIG: begin
                if (ssg_do_vld) begin
                    do_bit_d = ssg_do;
                    do_sig_d = 1'b1;
                    do_vld_d = 1'b1;
                    gap_d    = '0;
                    cnt_d    = cnt + 1'b1;
                    if (cnt == CNT_W'(SIG_BITS - 1)) begin
                        state_d = PLD_LD;
                    end
                end else if (gap == GAP_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    aborted_d     = 1'b1;
                    state_d       = DONE;
                end else begin
                    gap_d = gap + 1'b1;
                end
            end

            PLD_LD: begin
                cnt_d   = '0;
                gap_d   = '0;
                state_d = PLD;
            end

            PLD: begin
                if (pld_do_vld) begin
                    do_bit_d = pld_do;
                    do_sig_d = 1'b0;
                    do_vld_d = 1'b1;
                    gap_d    = '0;
                    cnt_d    = cnt + 1'b1;
                    if (cnt == pld_last) begin
                        state_d = DONE;
                    end
                end else if (gap == GAP_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    aborted_d     = 1'b1;
                    state_d       = DONE;
                end else begin
                    gap_d = gap + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            gap         <= '0;
            aborted     <= 1'b0;
            ssg_di_len  <= '0;
            ssg_di_type <= '0;
            ssg_di_vld  <= 1'b0;
            pld_rd_en   <= 1'b0;
            done_rst    <= 1'b0;
            do_bit      <= 1'b0;
            do_vld      <= 1'b0;
            do_sig      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            gap         <= gap_d;
            aborted     <= aborted_d;
            ssg_di_len  <= lat_len_d;
            ssg_di_type <= lat_type_d;
            // Strobes are registered from the next state so they line up with it.
            ssg_di_vld  <= (state_d == SIG_LD);
            pld_rd_en   <= (state_d == PLD_LD);
            done_rst    <= (state_d == DONE);
            frame_done  <= (state_d == DONE) && !aborted_d;
            busy        <= (state_d != IDLE);
            do_bit      <= do_bit_d;
            do_vld      <= do_vld_d;
            do_sig      <= do_sig_d;
            err_len     <= err_len_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_seq.sv
// Self-checking bench for tx_frame_seq: a frame-level reference model checked every
// cycle, plus hand-computed literal expectations for each directed scenario.
module tb_tx_frame_seq;

    localparam int MAX_LEN = 4095;
    localparam int TMO     = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [3:0]  rate;
    logic [15:0] ssg_di_len;
    logic [3:0]  ssg_di_type;
    logic        ssg_di_vld;
    logic        ssg_do, ssg_do_vld;
    logic        pld_rd_en;
    logic        pld_do, pld_do_vld;
    logic        done_rst, do_bit, do_vld, do_sig, busy;
    logic        frame_done, err_len, err_timeout;

    tx_frame_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .rate        (rate),
        .ssg_di_len  (ssg_di_len),
        .ssg_di_type (ssg_di_type),
        .ssg_di_vld  (ssg_di_vld),
        .ssg_do      (ssg_do),
        .ssg_do_vld  (ssg_do_vld),
        .pld_rd_en   (pld_rd_en),
        .pld_do      (pld_do),
        .pld_do_vld  (pld_do_vld),
        .done_rst    (done_rst),
        .do_bit      (do_bit),
        .do_vld      (do_vld),
        .do_sig      (do_sig),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    logic [29:0] outvec;
    assign outvec = {ssg_di_len, ssg_di_type, ssg_di_vld, pld_rd_en, done_rst,
                     do_bit, do_vld, do_sig, busy, frame_done, err_len, err_timeout};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which part of the frame is live and how many bits remain.
    localparam int M_IDLE = 0, M_SIGLOAD = 1, M_SIGNAL = 2, M_PLDLOAD = 3, M_PAYLOAD = 4, M_END = 5;
    int   phase = M_IDLE;
    int   bits_left = 0;
    int   idle_run = 0;
    int   m_len = 0;
    logic [15:0] e_di_len;
    logic [3:0]  e_di_type;
    logic e_di_vld, e_rd_en, e_done_rst, e_do, e_do_vld, e_do_sig, e_busy;
    logic e_frame_done, e_err_len, e_err_timeout;

    always @(posedge clk) begin
        e_di_vld = 0; e_rd_en = 0; e_done_rst = 0; e_do_vld = 0;
        e_frame_done = 0; e_err_len = 0; e_err_timeout = 0;
        if (rst) begin
            phase = M_IDLE;
            e_do = 0; e_do_sig = 0; e_di_len = 0; e_di_type = 0;
        end else begin
            case (phase)
                M_IDLE: if (start) begin
                    if (len >= 1 && len <= MAX_LEN) begin
                        m_len = int'(len); e_di_len = len; e_di_type = rate;
                        phase = M_SIGLOAD; e_di_vld = 1;
                    end else begin
                        e_err_len = 1;
                    end
                end
                M_SIGLOAD: begin phase = M_SIGNAL; bits_left = 24; idle_run = 0; end
                M_PLDLOAD: begin phase = M_PAYLOAD; bits_left = 8 * m_len; idle_run = 0; end
                M_END:     phase = M_IDLE;
                default: begin
                    if ((phase == M_SIGNAL && ssg_do_vld) || (phase == M_PAYLOAD && pld_do_vld)) begin
                        e_do_vld = 1;
                        e_do_sig = (phase == M_SIGNAL);
                        e_do = (phase == M_SIGNAL) ? ssg_do : pld_do;
                        bits_left--;
                        idle_run = 0;
                        if (bits_left == 0) begin
                            if (phase == M_SIGNAL) begin
                                phase = M_PLDLOAD; e_rd_en = 1;
                            end else begin
                                phase = M_END; e_done_rst = 1; e_frame_done = 1;
                            end
                        end
                    end else begin
                        idle_run++;
                        if (idle_run == TMO) begin
                            phase = M_END; e_done_rst = 1; e_err_timeout = 1;
                        end
                    end
                end
            endcase
        end
        e_busy = (phase != M_IDLE);
    end

    // Compare process and event monitor, both on the falling edge.
    bit cmp_en = 0;
    int n_sigbits, n_pldbits, n_ssgld, n_pldrd, n_done, n_fdone, n_errlen, n_errto, n_busy;
    int n_done_fd, mon_cyc, t_done, t_ssgld;
    int last_di_len, last_di_type, busy_after_done;
    bit prev_done = 0;

    always @(negedge clk) begin
        mon_cyc++;
        if (cmp_en) begin
            check("cycle_outputs", int'(outvec),
                  int'({e_di_len, e_di_type, e_di_vld, e_rd_en, e_done_rst, e_do, e_do_vld,
                        e_do_sig, e_busy, e_frame_done, e_err_len, e_err_timeout}));
            if (do_vld && do_sig)  n_sigbits++;
            if (do_vld && !do_sig) n_pldbits++;
            if (ssg_di_vld) begin
                n_ssgld++; t_ssgld = mon_cyc;
                last_di_len = int'(ssg_di_len); last_di_type = int'(ssg_di_type);
            end
            if (pld_rd_en)   n_pldrd++;
            if (done_rst)    begin n_done++; t_done = mon_cyc; end
            if (done_rst && frame_done) n_done_fd++;
            if (frame_done)  n_fdone++;
            if (err_len)     n_errlen++;
            if (err_timeout) n_errto++;
            if (busy)        n_busy++;
            if (prev_done)   busy_after_done = int'(busy);
            prev_done = done_rst;
        end
    end

    task automatic clr_counters();
        n_sigbits = 0; n_pldbits = 0; n_ssgld = 0; n_pldrd = 0; n_done = 0; n_fdone = 0;
        n_errlen = 0; n_errto = 0; n_busy = 0; n_done_fd = 0; busy_after_done = -1;
        last_di_len = -1; last_di_type = -1;
    endtask

    // Stimulus: inputs change 1 time unit after the rising edge.
    bit ssg_on = 0;
    int pld_mode = 0;
    int cyc_n = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
        ssg_do     = 1'($urandom_range(0, 1));
        pld_do     = 1'($urandom_range(0, 1));
        ssg_do_vld = ssg_on;
        pld_do_vld = (pld_mode == 1) || (pld_mode == 2 && cyc_n[0]);
    endtask

    task automatic pulse_start(input int l, input int r);
        len = 16'(l); rate = 4'(r); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin step(); k++; end
        check(name, int'(n_done != 0), 1);
        step(); step();
    endtask

    task automatic wait_rd_en(input string name);
        int k = 0;
        while (!pld_rd_en && k < 200) begin step(); k++; end
        check(name, int'(pld_rd_en), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int saved_done, saved_fdone;
        rst = 1'b1; start = 1'b0; len = '0; rate = '0;
        ssg_do = 0; ssg_do_vld = 0; pld_do = 0; pld_do_vld = 0;
        step();
        cmp_en = 1;
        step(); step();
        check("reset_state", int'(outvec), 0);
        rst = 1'b0;
        step();

        // T1: single-byte frame, generators streaming continuously.
        clr_counters();
        ssg_on = 1; pld_mode = 1;
        pulse_start(1, 4'hB);
        run_until_done("t1_frame_end", 200);
        check("t1_ssg_load_count", n_ssgld, 1);
        check("t1_di_len", last_di_len, 1);
        check("t1_di_type", last_di_type, 'hB);
        check("t1_sig_bits", n_sigbits, 24);
        check("t1_rd_en_count", n_pldrd, 1);
        check("t1_pld_bits", n_pldbits, 8);
        check("t1_done_with_fdone", n_done_fd, 1);
        check("t1_busy_after_done", busy_after_done, 0);
        ssg_on = 0; pld_mode = 0;

        // T2: out-of-range lengths are rejected; MAX_LEN is accepted.
        clr_counters();
        pulse_start(0, 3);
        step(); step();
        pulse_start(4096, 3);
        step(); step();
        check("t2_err_len_count", n_errlen, 2);
        check("t2_busy_cycles", n_busy, 0);
        check("t2_no_strobes", n_ssgld + n_pldrd + n_done, 0);
        pulse_start(MAX_LEN, 5);
        step(); step();
        check("t2_max_len_loaded", last_di_len, MAX_LEN);
        check("t2_max_len_no_err", n_errlen, 2);
        rst = 1'b1; step(); rst = 1'b0; step();

        // T3: toggling payload valid with stray SIGNAL valids during payload.
        clr_counters();
        ssg_on = 1; pld_mode = 2;
        pulse_start(100, 2);
        run_until_done("t3_frame_end", 3000);
        check("t3_sig_bits", n_sigbits, 24);
        check("t3_pld_bits", n_pldbits, 800);
        check("t3_frame_done", n_fdone, 1);
        ssg_on = 0; pld_mode = 0;

        // T4: payload stalls after 10 bits until the timeout aborts the frame.
        clr_counters();
        ssg_on = 1; pld_mode = 0;
        pulse_start(4, 1);
        wait_rd_en("t4_rd_en_seen");
        pld_mode = 1;
        repeat (10) step();
        pld_mode = 0;
        run_until_done("t4_abort_end", 1200);
        check("t4_err_timeout", n_errto, 1);
        check("t4_no_frame_done", n_fdone, 0);
        check("t4_pld_bits", n_pldbits, 10);
        check("t4_busy_after_done", busy_after_done, 0);
        clr_counters();
        pld_mode = 1;
        pulse_start(1, 6);
        run_until_done("t4_next_frame_end", 200);
        check("t4_next_frame_done", n_fdone, 1);
        check("t4_next_pld_bits", n_pldbits, 8);
        ssg_on = 0; pld_mode = 0;

        // T5: start held high through a frame, then reset during payload.
        clr_counters();
        ssg_on = 1; pld_mode = 1;
        len = 16'd2; rate = 4'd3; start = 1'b1;
        run_until_done("t5_first_frame_end", 200);
        begin
            int k = 0;
            while (n_ssgld < 2 && k < 20) begin step(); k++; end
        end
        check("t5_second_load", n_ssgld, 2);
        check("t5_restart_gap", t_ssgld - t_done, 2);
        wait_rd_en("t5_rd_en_seen");
        step(); step(); step();
        saved_done = n_done; saved_fdone = n_fdone;
        rst = 1'b1;
        step();
        check("t5_rst_outputs_zero", int'(outvec), 0);
        start = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        check("t5_no_done_after_rst", n_done, saved_done);
        check("t5_no_fdone_after_rst", n_fdone, saved_fdone);
        check("t5_idle_after_rst", int'(busy), 0);
        ssg_on = 0; pld_mode = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
